// File: rtl/data_mem_responder_pkg.sv
// Shared types for the wait-state data-memory responder: access sizes, FSM states, lane helpers.
// Optional access-error checking is enabled by defining MEM_ERR_EN.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } mr_state_e;

  localparam int LAT_W = 4;

  // Byte lanes touched by an access; reserved size behaves like a word.
  function automatic logic [3:0] lane_enable(mem_size_e size, logic [1:0] addr_lo);
    case (size)
      SIZE_B:  return 4'b0001 << addr_lo;
      SIZE_H:  return addr_lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic access_error(mem_size_e size, logic [1:0] addr_lo);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return addr_lo[0];
      SIZE_W:  return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_lane_align.sv
// Combinational little-endian lane steering: store merge into the addressed word and
// load extraction with zero/sign extension.
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] new_word_o,
  output logic [31:0] rdata_o
);

  mem_size_e   size;
  logic [3:0]  lane_en;
  logic [1:0]  lane;
  logic [31:0] wrep;
  logic [31:0] shifted;

  // NOTE: every signal driven here gets a default before any branch so no latch is inferred.
  always_comb begin
    size    = mem_size_e'(size_i);
    lane_en = lane_enable(size, addr_lo_i);
    lane    = 2'b00;
    wrep    = wdata_i;
    case (size)
      SIZE_B: begin
        lane = addr_lo_i;
        wrep = {4{wdata_i[7:0]}};
      end
      SIZE_H: begin
        lane = {addr_lo_i[1], 1'b0};
        wrep = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase

    for (int i = 0; i < 4; i++) begin
      new_word_o[8*i +: 8] = lane_en[i] ? wrep[8*i +: 8] : word_i[8*i +: 8];
    end

    shifted = word_i >> {lane, 3'b000};
    case (size)
      SIZE_B:  rdata_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      SIZE_H:  rdata_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Valid/ready data-memory responder with programmable wait states (IDLE -> WAIT -> RESP).
// Define MEM_ERR_EN to flag misaligned and reserved-size accesses on resp_err.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  typedef struct packed {
    logic                  write;
    logic [1:0]            size;
    logic                  sgn;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
  } req_t;

  mr_state_e              state_q, state_d;
  logic [LAT_W-1:0]       cnt_q, cnt_d;
  req_t                   req_q, req_d, req_in, cur;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [31:0]            mem_q [DEPTH];

  logic                   commit;
  logic                   cur_err;
  logic [ADDR_WIDTH-3:0]  widx;
  logic [31:0]            new_word;
  logic [31:0]            load_data;
  logic                   unused_addr;

  assign req_in      = '{write: req_write, size: req_size, sgn: req_signed,
                         addr: req_addr[ADDR_WIDTH-1:0], wdata: req_wdata};
  assign unused_addr = ^req_addr[31:ADDR_WIDTH];

  // With zero wait states the commit happens on the accept edge, straight from the inputs.
  assign cur  = (state_q == ST_IDLE) ? req_in : req_q;
  assign widx = cur.addr[ADDR_WIDTH-1:2];

`ifdef MEM_ERR_EN
  assign cur_err = access_error(mem_size_e'(cur.size), cur.addr[1:0]);
`else
  assign cur_err = 1'b0;
`endif

  mem_lane_align u_align (
    .word_i     (mem_q[widx]),
    .wdata_i    (cur.wdata),
    .size_i     (cur.size),
    .signed_i   (cur.sgn),
    .addr_lo_i  (cur.addr[1:0]),
    .new_word_o (new_word),
    .rdata_o    (load_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    commit     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = rst;
        if (req_valid) begin
          req_d = req_in;
          cnt_d = LAT_W'(LATENCY);
          if (LATENCY == 0) begin
            commit  = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LAT_W'(1)) begin
          commit  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (commit) begin
      err_d   = cur_err;
      rdata_d = (cur.write || cur_err) ? 32'h0 : load_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the array is cleared on reset, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (commit && cur.write && !cur_err) begin
      mem_q[widx] <= new_word;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
